fp32_mul_issue_buffer: RTL and testbench

- Valid/ready issue and result-buffer adapter wrapped around the fixed-latency fpMultiply32nr pipeline.
- Accepts operand packets upstream, registers them into the multiplier, and tracks in-flight ops with a valid/tag shadow shift register.
- Captures results, flags and tag into a result FIFO for a back-pressured consumer.
- Credit accounting ensures the free-running multiplier never produces a result the FIFO cannot hold.

---
 rtl/fp32_mul_issue_buffer.sv | 135 +++++++++++++
 tb/tb_fp32_mul_issue_buffer.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp32_mul_issue_buffer.sv
// Valid/ready issue stage and in-order result FIFO wrapped around a free-running
// fixed-latency FP32 multiplier. Define FP32MUL_IBUF_FLUSH_EN to add a synchronous flush port.
module fp32_mul_issue_buffer #(
  parameter int LATENCY = 8,
  parameter int DEPTH   = 16,
  parameter int TAG_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
`ifdef FP32MUL_IBUF_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [2:0]       in_rm,
  input  logic [TAG_W-1:0] in_tag,
  output logic             mul_ce,
  output logic [31:0]      mul_a,
  output logic [31:0]      mul_b,
  output logic [2:0]       mul_rm,
  input  logic [31:0]      mul_o,
  input  logic             mul_sign_exe,
  input  logic             mul_inf,
  input  logic             mul_overflow,
  input  logic             mul_underflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_o,
  output logic [3:0]       out_flags,
  output logic [TAG_W-1:0] out_tag
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [31:0]      o;
    logic [3:0]       flags;
    logic [TAG_W-1:0] tag;
  } res_t;

  logic flush_i;
`ifdef FP32MUL_IBUF_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  logic [LATENCY-1:0]            vld_pipe;
  logic [LATENCY-1:0][TAG_W-1:0] tag_pipe;
  logic [CW-1:0]                 sh_cnt, fifo_cnt;
  logic [AW-1:0]                 wr_ptr, rd_ptr;
  res_t                          mem [DEPTH];
  res_t                          head;
  logic [CW:0]                   outstanding;
  logic                          accept, cap, pop;

  // Credits cover both in-flight ops and buffered results, so a capture always has a free slot.
  assign outstanding = {1'b0, sh_cnt} + {1'b0, fifo_cnt};
  assign in_ready    = !rst && !flush_i && (outstanding < (CW+1)'(DEPTH));
  assign accept      = in_valid && in_ready;
  assign cap         = vld_pipe[LATENCY-1];
  assign out_valid   = (fifo_cnt != '0);
  assign pop         = out_valid && out_ready;
  assign mul_ce      = !rst;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_a  <= '0;
      mul_b  <= '0;
      mul_rm <= '0;
    end else if (accept) begin
      mul_a  <= in_a;
      mul_b  <= in_b;
      mul_rm <= in_rm;
    end
  end

  // Shadow of the multiplier pipeline: stage LATENCY-1 lines up with mul_o.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      tag_pipe <= '0;
    end else begin
      vld_pipe[0] <= accept;
      tag_pipe[0] <= in_tag;
      for (int i = 1; i < LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        tag_pipe[i] <= tag_pipe[i-1];
      end
      if (flush_i) vld_pipe <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_cnt   <= '0;
      fifo_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else if (flush_i) begin
      sh_cnt   <= '0;
      fifo_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      sh_cnt   <= sh_cnt + CW'(accept) - CW'(cap);
      fifo_cnt <= fifo_cnt + CW'(cap) - CW'(pop);
      if (cap) wr_ptr <= ptr_inc(wr_ptr);
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
    end
  end

  always_ff @(posedge clk) begin
    if (cap && !flush_i)
      mem[wr_ptr] <= {mul_o, mul_sign_exe, mul_inf, mul_overflow, mul_underflow,
                      tag_pipe[LATENCY-1]};
  end

  // Storage is not reset; the head is masked to zero while the FIFO is empty.
  assign head      = mem[rd_ptr];
  assign out_o     = out_valid ? head.o     : '0;
  assign out_flags = out_valid ? head.flags : '0;
  assign out_tag   = out_valid ? head.tag   : '0;

  a_fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(cap && !flush_i && (fifo_cnt == CW'(DEPTH))));

endmodule

// File: tb/tb_fp32_mul_issue_buffer.sv
// Bench for fp32_mul_issue_buffer: behavioural FP32 multiplier pipeline as the environment,
// a queue scoreboard of outstanding ops, and per-scenario tasks.
module tb_fp32_mul_issue_buffer;
  localparam int LAT   = 8;
  localparam int DEPTH = 16;
  localparam int TW    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   in_a = '0, in_b = '0;
  logic [2:0]    in_rm = '0;
  logic [TW-1:0] in_tag = '0;
  logic          mul_ce;
  logic [31:0]   mul_a, mul_b;
  logic [2:0]    mul_rm;
  logic [31:0]   mul_o;
  logic          mul_sign_exe, mul_inf, mul_overflow, mul_underflow;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_o;
  logic [3:0]    out_flags;
  logic [TW-1:0] out_tag;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  fp32_mul_issue_buffer #(.LATENCY(LAT), .DEPTH(DEPTH), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst),
`ifdef FP32MUL_IBUF_FLUSH_EN
    .flush(flush),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_rm(in_rm), .in_tag(in_tag),
    .mul_ce(mul_ce), .mul_a(mul_a), .mul_b(mul_b), .mul_rm(mul_rm),
    .mul_o(mul_o), .mul_sign_exe(mul_sign_exe), .mul_inf(mul_inf),
    .mul_overflow(mul_overflow), .mul_underflow(mul_underflow),
    .out_valid(out_valid), .out_ready(out_ready), .out_o(out_o),
    .out_flags(out_flags), .out_tag(out_tag)
  );

  // Returns {sign_exe, inf, overflow, underflow, result}; subnormals treated as zero,
  // rm==0 rounds to nearest even, other modes truncate.
  function automatic logic [35:0] fmul(input logic [31:0] a, input logic [31:0] b,
                                       input logic [2:0] rm);
    logic s, g, st;
    int ea, eb, e;
    logic [47:0] p;
    logic [23:0] m;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if (ea == 0 || eb == 0) return {s, 3'b000, s, 31'd0};
    if (ea == 255 || eb == 255) return {s, 3'b100, s, 8'hFF, 23'd0};
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = ea + eb - 127;
    if (p[47]) begin
      m = p[47:24]; g = p[23]; st = |p[22:0]; e = e + 1;
    end else begin
      m = p[46:23]; g = p[22]; st = |p[21:0];
    end
    if (rm == 3'd0 && g && (st || m[0])) begin
      m = m + 24'd1;
      if (m == 24'd0) begin m = 24'h800000; e = e + 1; end
    end
    if (e >= 255) return {s, 3'b110, s, 8'hFF, 23'd0};
    if (e <= 0) return {s, 3'b001, s, 31'd0};
    return {s, 3'b000, s, 8'(e), m[22:0]};
  endfunction

  // Environment multiplier: mul_o valid LATENCY-1 register stages after mul_a.
  logic [35:0] mpipe [0:LAT-2];
  always @(posedge clk) begin
    if (mul_ce) begin
      mpipe[0] <= fmul(mul_a, mul_b, mul_rm);
      for (int i = 1; i < LAT - 1; i++) mpipe[i] <= mpipe[i-1];
    end
  end
  assign {mul_sign_exe, mul_inf, mul_overflow, mul_underflow, mul_o} = mpipe[LAT-2];

  typedef struct {
    logic [31:0]   o;
    logic [3:0]    f;
    logic [TW-1:0] tag;
    int            acc;
  } exp_t;
  exp_t q[$];

  // Scoreboard: every outstanding op lives in q from accept to pop.
  always @(posedge clk) begin
    exp_t e;
    logic [35:0] r;
    cyc = cyc + 1;
    if (rst || flush) begin
      q.delete();
    end else begin
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL pop_unexpected: got tag=%0d o=%h, expected no result", out_tag, out_o);
        end else begin
          if (out_o !== q[0].o || out_flags !== q[0].f || out_tag !== q[0].tag) begin
            errors++;
            $display("FAIL pop_data: got o=%h f=%b tag=%0d, expected o=%h f=%b tag=%0d",
                     out_o, out_flags, out_tag, q[0].o, q[0].f, q[0].tag);
          end
          q.delete(0);
        end
      end
      if (in_valid && in_ready) begin
        r     = fmul(in_a, in_b, in_rm);
        e.o   = r[31:0];
        e.f   = r[35:32];
        e.tag = in_tag;
        e.acc = cyc;
        q.push_back(e);
      end
    end
  end

  // Cycle checker: ready from credit count, valid from accept time + LATENCY.
  always @(negedge clk) begin
    logic exp_rdy, exp_ov;
    if (!rst) begin
      exp_rdy = !flush && (q.size() < DEPTH);
      exp_ov  = 1'b0;
      if (q.size() > 0) exp_ov = (cyc >= q[0].acc + LAT);
      checks++;
      if (in_ready !== exp_rdy) begin
        errors++;
        $display("FAIL in_ready: got %b, expected %b (outstanding=%0d)", in_ready, exp_rdy, q.size());
      end
      checks++;
      if (out_valid !== exp_ov) begin
        errors++;
        $display("FAIL out_valid: got %b, expected %b at cycle %0d", out_valid, exp_ov, cyc);
      end
      checks++;
      if (mul_ce !== 1'b1) begin
        errors++;
        $display("FAIL mul_ce: got %b, expected 1", mul_ce);
      end
      if (exp_ov && out_valid) begin
        checks++;
        if (out_tag !== q[0].tag || out_o !== q[0].o) begin
          errors++;
          $display("FAIL head: got tag=%0d o=%h, expected tag=%0d o=%h",
                   out_tag, out_o, q[0].tag, q[0].o);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm,
                        input logic [TW-1:0] tag);
    in_valid = 1'b1; in_a = a; in_b = b; in_rm = rm; in_tag = tag;
  endtask

  function automatic logic [31:0] rnd_fp();
    logic [7:0] e;
    e = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(100, 154));
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  task automatic test_reset();
    int stale;
    out_ready = 1'b0;
    step();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_hs: got out_valid=%b in_ready=%b, expected 0 0", out_valid, in_ready);
    end
    checks++;
    if (mul_ce !== 1'b0) begin errors++; $display("FAIL reset_ce: got %b, expected 0", mul_ce); end
    checks++;
    if (mul_a !== 32'd0 || mul_b !== 32'd0 || mul_rm !== 3'd0) begin
      errors++; $display("FAIL reset_mul: got a=%h b=%h rm=%0d, expected 0", mul_a, mul_b, mul_rm);
    end
    checks++;
    if (out_o !== 32'd0 || out_flags !== 4'd0 || out_tag !== '0) begin
      errors++; $display("FAIL reset_out: got o=%h f=%b tag=%0d, expected 0", out_o, out_flags, out_tag);
    end
    step();
    rst = 1'b0;
    // 5 back-to-back ops: after 5 more edges two are buffered, three in flight.
    for (int i = 0; i < 5; i++) begin
      set_op(rnd_fp(), rnd_fp(), 3'd0, TW'(i));
      step();
    end
    in_valid = 1'b0;
    repeat (5) step();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL reset_pre: got out_valid=%b, expected 1", out_valid); end
    #1 rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_release: got in_ready=%b out_valid=%b, expected 1 0", in_ready, out_valid);
    end
    out_ready = 1'b1;
    stale = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    checks++;
    if (stale != 0) begin errors++; $display("FAIL reset_stale: got %0d stale results, expected 0", stale); end
  endtask

  task automatic test_single();
    int n, lat;
    bit found;
    step();
    out_ready = 1'b1;
    set_op(32'h3FC00000, 32'h40000000, 3'd0, TW'(5));
    step();
    n = cyc;
    in_valid = 1'b0;
    found = 1'b0;
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid) begin found = 1'b1; lat = cyc - n; break; end
    end
    checks++;
    if (!found || lat != LAT) begin errors++; $display("FAIL single_latency: got %0d, expected %0d", lat, LAT); end
    checks++;
    if (out_o !== 32'h40400000) begin errors++; $display("FAIL single_o: got %h, expected 40400000", out_o); end
    checks++;
    if (out_tag !== TW'(5)) begin errors++; $display("FAIL single_tag: got %0d, expected 5", out_tag); end
    checks++;
    if (out_flags !== 4'b0000) begin errors++; $display("FAIL single_flags: got %b, expected 0000", out_flags); end
    step();
  endtask

  task automatic test_streaming();
    int nres, first, last;
    nres = 0; first = -1; last = -1;
    step();
    out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 32; i++) begin
          checks++;
          if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready: got 0 at op %0d, expected 1", i); end
          set_op(rnd_fp(), rnd_fp(), 3'($urandom_range(0, 4)), TW'(i % 16));
          step();
        end
        in_valid = 1'b0;
      end
      begin
        for (int k = 0; k < 32 + LAT + 10; k++) begin
          @(negedge clk);
          if (out_valid) begin
            checks++;
            if (out_tag !== TW'(nres % 16)) begin
              errors++; $display("FAIL stream_tag: got %0d, expected %0d", out_tag, nres % 16);
            end
            if (first < 0) first = cyc;
            last = cyc;
            nres++;
          end
        end
      end
    join
    checks++;
    if (nres != 32 || last - first != 31) begin
      errors++; $display("FAIL stream_rate: got %0d results over %0d cycles, expected 32 over 32", nres, last - first + 1);
    end
  endtask

  task automatic test_backpressure();
    int acc, n;
    step();
    out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 30; i++) begin
      set_op(rnd_fp(), rnd_fp(), 3'd0, TW'(i % 16));
      if (in_ready) acc++;
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (acc != DEPTH) begin errors++; $display("FAIL bp_accepts: got %0d, expected %0d", acc, DEPTH); end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready: got %b, expected 0", in_ready); end
    repeat (LAT + 2) step();
    out_ready = 1'b1;
    n = 0;
    for (int k = 0; k < DEPTH + 4; k++) begin
      @(negedge clk);
      if (k == 0) begin
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_pre: got %b, expected 0", in_ready); end
      end
      if (k == 1) begin
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_post: got %b, expected 1", in_ready); end
      end
      if (out_valid) n++;
      step();
    end
    checks++;
    if (n != DEPTH) begin errors++; $display("FAIL bp_drain: got %0d results, expected %0d", n, DEPTH); end
  endtask

  task automatic test_overflow();
    int seen;
    step();
    out_ready = 1'b1;
    set_op(32'h3F800000, 32'h3F800000, 3'd0, TW'(8)); step();
    set_op(32'h7F000000, 32'h7F000000, 3'd0, TW'(9)); step();
    set_op(32'h3F800000, 32'h3F800000, 3'd0, TW'(10)); step();
    in_valid = 1'b0;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid) begin
        seen++;
        checks++;
        if (out_tag == TW'(9)) begin
          if (out_o !== 32'h7F800000 || out_flags !== 4'b0110) begin
            errors++; $display("FAIL ovf_result: got o=%h f=%b, expected 7f800000 0110", out_o, out_flags);
          end
        end else if (out_o !== 32'h3F800000 || out_flags !== 4'b0000) begin
          errors++; $display("FAIL ovf_neighbour: tag %0d got o=%h f=%b, expected 3f800000 0000", out_tag, out_o, out_flags);
        end
      end
    end
    checks++;
    if (seen != 3) begin errors++; $display("FAIL ovf_count: got %0d, expected 3", seen); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) != 0) set_op(rnd_fp(), rnd_fp(), 3'($urandom_range(0, 4)), TW'($urandom));
      else in_valid = 1'b0;
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 100 && q.size() != 0; k++) step();
    step();
    checks++;
    if (q.size() != 0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL random_drain: got %0d left, out_valid=%b, expected 0 0", q.size(), out_valid);
    end
  endtask

`ifdef FP32MUL_IBUF_FLUSH_EN
  task automatic test_flush();
    bit found;
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      set_op(rnd_fp(), rnd_fp(), 3'd0, TW'(i));
      step();
    end
    in_valid = 1'b0;
    repeat (4) step();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_pre: got out_valid=%b, expected 1", out_valid); end
    #1 flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_empty: got out_valid=%b, expected 0", out_valid); end
    out_ready = 1'b1;
    step();
    set_op(32'h3FC00000, 32'h40000000, 3'd0, TW'(12));
    step();
    in_valid = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid) begin found = 1'b1; break; end
    end
    checks++;
    if (!found || out_tag !== TW'(12) || out_o !== 32'h40400000) begin
      errors++; $display("FAIL flush_next: got valid=%b tag=%0d o=%h, expected 1 12 40400000", found, out_tag, out_o);
    end
    step();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_streaming();
    test_backpressure();
    test_overflow();
    test_random();
`ifdef FP32MUL_IBUF_FLUSH_EN
    test_flush();
`endif
    repeat (LAT + 4) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
